mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX_CYCLES, default 16: maximum consecutive cycles the bus stays in LOCKED before forced release.
REQ-002 SHALL have ports clk input 1, rising-edge clock; async_rst_n input 1, reset, asynchronous, active-low.
REQ-003 SHALL have fetch ports: if_req in 1, request; if_addr in 30, word address; if_gnt out 1, grant pulse; if_ack out 1, response pulse; if_rdata out 32, read data.
REQ-004 SHALL have data ports: d_req in 1; d_addr in 30; d_wdata in 32; d_mask in 4, byte enables; d_we in 1, 1=write; d_lock in 1, bus lock; d_gnt out 1; d_ack out 1; d_rdata out 32.
REQ-005 SHALL have memory ports: m_req out 1; m_addr out 30; m_wdata out 32; m_mask out 4; m_we out 1; m_ready in 1, request accepted; m_rvalid in 1, response valid; m_rdata in 32.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, LOCKED; exactly one memory transaction outstanding.
REQ-007 IDLE: SHALL arbitrate among asserted if_req/d_req; winner's x_gnt pulses 1 cycle; address/data/mask/we/lock captured; next state ISSUE.
REQ-008 Fetch transactions SHALL drive m_we=0 and m_mask=4'hF.
REQ-009 ISSUE: m_req=1 with captured fields held stable until m_req&&m_ready, then WAIT; m_req SHALL drop the cycle after acceptance.
REQ-010 WAIT: on m_rvalid, SHALL register m_rdata into the owner's rdata and go to RESP; owner's x_ack=1 for exactly the RESP cycle (1-cycle latency from m_rvalid).
REQ-011 Writes SHALL also complete via m_rvalid; d_rdata for writes is don't-care, d_ack still pulses.
REQ-012 RESP: if owner was data and captured d_lock=1, next state LOCKED; otherwise IDLE.
REQ-013 LOCKED: only d_req SHALL be granted (behaves as IDLE restricted to data); if_req held off, no if_gnt.
REQ-014 LOCKED: 8-bit lock counter SHALL clear on entry and increment each LOCKED cycle without a grant; at count == LOCK_MAX_CYCLES-1, SHALL force IDLE next cycle.
REQ-015 Data transaction granted from LOCKED with d_lock=0 SHALL return to IDLE after RESP (lock release).
REQ-016 Requester SHALL hold x_req and fields until x_gnt; fields may change after x_gnt.
REQ-017 m_rvalid outside WAIT SHALL be ignored: no ack, no rdata update.
REQ-018 Non-owner x_ack and x_gnt SHALL never assert; if_gnt and d_gnt never high in the same cycle.

Reset
REQ-019 async_rst_n low SHALL immediately force state IDLE, m_req/m_we/if_gnt/d_gnt/if_ack/d_ack 0, m_addr/m_wdata/m_mask/if_rdata/d_rdata 0, lock counter 0, round-robin pointer "fetch last".
REQ-020 Reset mid-transaction SHALL abandon the outstanding transaction; its later m_rvalid is discarded per REQ-017.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL grant the port not granted last (pointer updated on every grant, reset "fetch last" so data wins first tie).
REQ-022 When ARB_ROUND_ROBIN_EN is undefined, data port SHALL have fixed priority over fetch; no pointer register.

Verification
REQ-023 Reset released, if_req=1, if_addr=0x10, m_ready=1, m_rvalid 2 cycles after acceptance with m_rdata=0xDEADBEEF -> if_gnt 1 cycle, m_addr=0x10, m_mask=F, m_we=0, if_ack one cycle after m_rvalid, if_rdata=0xDEADBEEF.
REQ-024 if_req and d_req same cycle, macro undefined -> d_gnt first; fetch granted after d_ack; with ARB_ROUND_ROBIN_EN, two back-to-back ties alternate d then if.
REQ-025 d_req write, d_addr=0x20, d_wdata=0x50FF, d_mask=0011, d_lock=1; if_req held -> LOCKED after d_ack, if_gnt withheld; next data request with d_lock=0 completes, then if_gnt issued.
REQ-026 Locked data transaction, then no d_req, LOCK_MAX_CYCLES=4 -> forced IDLE after 4 LOCKED cycles, pending if_req granted next cycle.
REQ-027 m_ready=0 for 5 cycles in ISSUE -> m_req and fields stable all 5 cycles; async_rst_n pulsed low in WAIT -> outputs 0 immediately; subsequent m_rvalid produces no ack.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data and memory-side signal bundle of mem_bus_arbiter.
// master is the arbiter's view; slave is the requesters' and memory's view.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [29:0] if_addr;
    logic        if_gnt;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        d_we;
    logic        d_lock;
    logic        d_gnt;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;
    logic        m_we;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_addr, d_wdata, d_mask, d_we, d_lock,
               m_ready, m_rvalid, m_rdata,
        output if_gnt, if_ack, if_rdata, d_gnt, d_ack, d_rdata,
               m_req, m_addr, m_wdata, m_mask, m_we
    );

    modport slave (
        output if_req, if_addr, d_req, d_addr, d_wdata, d_mask, d_we, d_lock,
               m_ready, m_rvalid, m_rdata,
        input  if_gnt, if_ack, if_rdata, d_gnt, d_ack, d_rdata,
               m_req, m_addr, m_wdata, m_mask, m_we
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fetch/data arbiter onto a single-outstanding memory bus with data-side bus lock.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data has fixed priority over fetch.
module mem_bus_arbiter #(
    parameter int LOCK_MAX_CYCLES = 16
) (
    input logic               clk,
    input logic               async_rst_n,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, LOCKED} state_t;
    state_t      state, state_nxt;
    logic        open_arb, pick_d, pick_i, owner_d, lock_q;
    logic [7:0]  lock_cnt;

    assign open_arb = state == IDLE || state == LOCKED;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = open_arb && bus.d_req && (state == LOCKED || !bus.if_req || !last_d);
    always_ff @(posedge clk or negedge async_rst_n)
        if (!async_rst_n) last_d <= 1'b0;
        else if (pick_d || pick_i) last_d <= pick_d;
`else
    assign pick_d = open_arb && bus.d_req;
`endif
    assign pick_i = state == IDLE && bus.if_req && !pick_d;

    always_ff @(posedge clk or negedge async_rst_n)
        if (!async_rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick_d || pick_i ? ISSUE : IDLE;
            ISSUE:   state_nxt = bus.m_ready ? WAIT : ISSUE;
            WAIT:    state_nxt = bus.m_rvalid ? RESP : WAIT;
            RESP:    state_nxt = owner_d && lock_q ? LOCKED : IDLE;
            LOCKED:  state_nxt = pick_d ? ISSUE : lock_cnt == 8'(LOCK_MAX_CYCLES - 1) ? IDLE : LOCKED;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.m_req  = state == ISSUE;
    assign bus.if_ack = state == RESP && !owner_d;
    assign bus.d_ack  = state == RESP && owner_d;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            bus.if_gnt   <= 1'b0;
            bus.d_gnt    <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.m_mask   <= '0;
            bus.m_we     <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
            owner_d      <= 1'b0;
            lock_q       <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            bus.if_gnt <= pick_i;
            bus.d_gnt  <= pick_d;
            if (pick_d) begin
                owner_d     <= 1'b1;
                bus.m_addr  <= bus.d_addr;
                bus.m_wdata <= bus.d_wdata;
                bus.m_mask  <= bus.d_mask;
                bus.m_we    <= bus.d_we;
                lock_q      <= bus.d_lock;
            end else if (pick_i) begin
                owner_d     <= 1'b0;
                bus.m_addr  <= bus.if_addr;
                bus.m_mask  <= 4'hF;
                bus.m_we    <= 1'b0;
                lock_q      <= 1'b0;
            end
            // responses outside WAIT belong to no one and are dropped
            if (state == WAIT && bus.m_rvalid) begin
                if (owner_d) bus.d_rdata <= bus.m_rdata;
                else bus.if_rdata <= bus.m_rdata;
            end
            lock_cnt <= state == LOCKED && !pick_d ? lock_cnt + 8'd1 : 8'd0;
        end
    end
endmodule
